// File: rtl/reflet_context_regs.sv
// Reflet register bank with write-back, PC/SP stepping and a nested interrupt context stack.
// One-cycle state update on enabled, non-stalled edges; reads are combinational with no bypass.
module reflet_context_regs #(
  parameter int                  wordsize   = 16,
  parameter int                  int_levels = 4,
  parameter logic [wordsize-1:0] pc_reset   = '0,
  parameter logic [wordsize-1:0] sp_reset   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                stall,
  input  logic                wr_valid,
  input  logic [3:0]          wr_index,
  input  logic [wordsize-1:0] wr_data,
  input  logic [1:0]          sp_op,
  input  logic                int_enter,
  input  logic [wordsize-1:0] int_vector,
  input  logic                int_return,
  input  logic [3:0]          rd_index,
  output logic [wordsize-1:0] rd_data,
  output logic [wordsize-1:0] wr_out,
  output logic [wordsize-1:0] sr_out,
  output logic [wordsize-1:0] pc_out,
  output logic [wordsize-1:0] sp_out,
  output logic                int_ack,
  output logic [3:0]          ctx_depth,
  output logic                ctx_overflow,
  output logic                ctx_underflow
);

  localparam logic [3:0] wr_id = 4'd0;
  localparam logic [3:0] sp_id = 4'd13;
  localparam logic [3:0] pc_id = 4'd14;
  localparam logic [3:0] sr_id = 4'd15;
  localparam logic [wordsize-1:0] sp_step   = wordsize'(wordsize / 8);
  localparam logic [3:0]          max_depth = 4'(int_levels);

  logic [wordsize-1:0] regs_q   [16];
  logic [wordsize-1:0] regs_d   [16];
  logic [wordsize-1:0] stk_pc_q [int_levels];
  logic [wordsize-1:0] stk_pc_d [int_levels];
  logic [wordsize-1:0] stk_wr_q [int_levels];
  logic [wordsize-1:0] stk_wr_d [int_levels];
  logic [wordsize-1:0] stk_sr_q [int_levels];
  logic [wordsize-1:0] stk_sr_d [int_levels];
  logic [3:0]          depth_q, depth_d;
  logic                ack_q, ack_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic                upd, do_push, do_pop;
  logic [wordsize-1:0] pop_pc, pop_wr, pop_sr;

  assign upd     = enable & ~stall;
  assign do_push = upd & int_enter & (depth_q < max_depth);
  assign do_pop  = upd & ~int_enter & int_return & (depth_q != 4'd0);

  // Top-of-stack lives at depth_q-1.
  always_comb begin
    pop_pc = '0;
    pop_wr = '0;
    pop_sr = '0;
    for (int i = 0; i < int_levels; i++) begin
      if (depth_q == 4'(i + 1)) begin
        pop_pc = stk_pc_q[i];
        pop_wr = stk_wr_q[i];
        pop_sr = stk_sr_q[i];
      end
    end
  end

  always_comb begin
    regs_d   = regs_q;
    stk_pc_d = stk_pc_q;
    stk_wr_d = stk_wr_q;
    stk_sr_d = stk_sr_q;
    depth_d  = depth_q;
    ack_d    = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (do_push) begin
      for (int i = 0; i < int_levels; i++) begin
        if (depth_q == 4'(i)) begin
          stk_pc_d[i] = regs_q[pc_id];
          stk_wr_d[i] = regs_q[wr_id];
          stk_sr_d[i] = regs_q[sr_id];
        end
      end
      regs_d[pc_id] = int_vector;
      depth_d       = depth_q + 4'd1;
      ack_d         = 1'b1;
    end else if (do_pop) begin
      regs_d[pc_id] = pop_pc;
      regs_d[wr_id] = pop_wr;
      regs_d[sr_id] = pop_sr;
      depth_d       = depth_q - 4'd1;
    end else if (upd) begin
      if (int_enter) ovf_d = 1'b1;
      else if (int_return) unf_d = 1'b1;
      case (sp_op)
        2'b01:   regs_d[sp_id] = regs_q[sp_id] + sp_step;
        2'b10:   regs_d[sp_id] = regs_q[sp_id] - sp_step;
        default: regs_d[sp_id] = regs_q[sp_id];
      endcase
      regs_d[pc_id] = regs_q[pc_id] + 1'b1;
      // Applied last so an explicit write wins over both SP step and PC increment.
      if (wr_valid) regs_d[wr_index] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      regs_q[pc_id] <= pc_reset;
      regs_q[sp_id] <= sp_reset;
      depth_q       <= 4'd0;
      ack_q         <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      depth_q <= depth_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    stk_pc_q <= stk_pc_d;
    stk_wr_q <= stk_wr_d;
    stk_sr_q <= stk_sr_d;
  end

  assign rd_data       = regs_q[rd_index];
  assign wr_out        = regs_q[wr_id];
  assign sr_out        = regs_q[sr_id];
  assign pc_out        = regs_q[pc_id];
  assign sp_out        = regs_q[sp_id];
  assign int_ack       = ack_q;
  assign ctx_depth     = depth_q;
  assign ctx_overflow  = ovf_q;
  assign ctx_underflow = unf_q;

endmodule

// File: tb/tb_reflet_context_regs.sv
// Bench for reflet_context_regs: directed vector table, async reset case, then random traffic vs. a model.
module tb_reflet_context_regs;

  localparam int LEVELS = 2;
  localparam logic [15:0] PC_RST = 16'h0100;
  localparam logic [15:0] SP_RST = 16'h8000;
  localparam int WR_IDX = 0, SP_IDX = 13, PC_IDX = 14, SR_IDX = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, st, wv, ie, ir;
  logic [3:0]  wi, rdi;
  logic [15:0] wd, iv;
  logic [1:0]  spop;
  logic [15:0] rd_data, wr_out, sr_out, pc_out, sp_out;
  logic        int_ack, ctx_overflow, ctx_underflow;
  logic [3:0]  ctx_depth;

  int n_cmp = 0;
  int n_fail = 0;

  reflet_context_regs #(
    .wordsize(16), .int_levels(LEVELS), .pc_reset(PC_RST), .sp_reset(SP_RST)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(en), .stall(st),
    .wr_valid(wv), .wr_index(wi), .wr_data(wd), .sp_op(spop),
    .int_enter(ie), .int_vector(iv), .int_return(ir), .rd_index(rdi),
    .rd_data(rd_data), .wr_out(wr_out), .sr_out(sr_out), .pc_out(pc_out), .sp_out(sp_out),
    .int_ack(int_ack), .ctx_depth(ctx_depth),
    .ctx_overflow(ctx_overflow), .ctx_underflow(ctx_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vectors: inputs applied for one edge, expected outputs after it.
  typedef struct {
    logic en, st, wv;
    logic [3:0] wi;
    logic [15:0] wd;
    logic [1:0] spop;
    logic ie;
    logic [15:0] iv;
    logic ir;
    logic [3:0] rdi;
    logic [15:0] e_pc, e_sp, e_rd;
    logic [3:0] e_dep;
    logic e_ack, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: architectural registers plus a queue of saved contexts.
  typedef struct { logic [15:0] pc, wr, sr; } ctx_t;
  logic [15:0] m_reg[16];
  ctx_t        m_stk[$];
  logic        m_ack, m_ovf, m_unf;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_reg[PC_IDX] = PC_RST;
    m_reg[SP_IDX] = SP_RST;
    m_stk.delete();
    m_ack = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step();
    ctx_t c;
    m_ack = 0;
    if (!en || st) return;
    if (ie && m_stk.size() < LEVELS) begin
      c.pc = m_reg[PC_IDX]; c.wr = m_reg[WR_IDX]; c.sr = m_reg[SR_IDX];
      m_stk.push_back(c);
      m_reg[PC_IDX] = iv;
      m_ack = 1;
    end else if (!ie && ir && m_stk.size() > 0) begin
      c = m_stk.pop_back();
      m_reg[PC_IDX] = c.pc; m_reg[WR_IDX] = c.wr; m_reg[SR_IDX] = c.sr;
    end else begin
      logic [15:0] pc_next, sp_next;
      if (ie) m_ovf = 1;
      else if (ir) m_unf = 1;
      pc_next = m_reg[PC_IDX] + 16'd1;
      sp_next = m_reg[SP_IDX];
      if (spop == 2'b01) sp_next = sp_next + 16'd2;
      if (spop == 2'b10) sp_next = sp_next - 16'd2;
      m_reg[PC_IDX] = pc_next;
      m_reg[SP_IDX] = sp_next;
      if (wv) m_reg[wi] = wd;
    end
  endtask

  task automatic drive(input vec_t v);
    en = v.en; st = v.st; wv = v.wv; wi = v.wi; wd = v.wd; spop = v.spop;
    ie = v.ie; iv = v.iv; ir = v.ir; rdi = v.rdi;
  endtask

  task automatic idle_inputs();
    en = 1; st = 0; wv = 0; wi = 0; wd = 0; spop = 0; ie = 0; iv = 0; ir = 0; rdi = 0;
  endtask

  initial begin
    //            en st wv wi     wd       sp  ie iv       ir rdi      pc       sp       rd       dep  ack ovf unf
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 0, 4'd3,  16'h0101, 16'h8000, 16'h0000, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 0, 4'd3,  16'h0102, 16'h8000, 16'h0000, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 0, 4'd0,  16'h0103, 16'h8000, 16'h0000, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd3,  16'hBEEF, 2'd0, 0, 16'h0000, 0, 4'd3,  16'h0104, 16'h8000, 16'hBEEF, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd14, 16'h0040, 2'd0, 0, 16'h0000, 0, 4'd3,  16'h0040, 16'h8000, 16'hBEEF, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 4'd3,  16'h1111, 2'd1, 0, 16'h0000, 0, 4'd3,  16'h0040, 16'h8000, 16'hBEEF, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0300, 0, 4'd3,  16'h0040, 16'h8000, 16'hBEEF, 4'd0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 4'd3,  16'h2222, 2'd1, 0, 16'h0000, 0, 4'd3,  16'h0040, 16'h8000, 16'hBEEF, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd13, 16'hFFFE, 2'd0, 0, 16'h0000, 0, 4'd13, 16'h0041, 16'hFFFE, 16'hFFFE, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd1, 0, 16'h0000, 0, 4'd13, 16'h0042, 16'h0000, 16'h0000, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd13, 16'h1234, 2'd2, 0, 16'h0000, 0, 4'd13, 16'h0043, 16'h1234, 16'h1234, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd2, 0, 16'h0000, 0, 4'd13, 16'h0044, 16'h1232, 16'h1232, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd0,  16'h0005, 2'd0, 0, 16'h0000, 0, 4'd0,  16'h0045, 16'h1232, 16'h0005, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd15, 16'h0080, 2'd0, 0, 16'h0000, 0, 4'd15, 16'h0046, 16'h1232, 16'h0080, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd14, 16'h0020, 2'd0, 0, 16'h0000, 0, 4'd0,  16'h0020, 16'h1232, 16'h0005, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd3,  16'hDEAD, 2'd1, 1, 16'h0300, 0, 4'd3,  16'h0300, 16'h1232, 16'hBEEF, 4'd1, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd0,  16'h0009, 2'd0, 0, 16'h0000, 0, 4'd0,  16'h0301, 16'h1232, 16'h0009, 4'd1, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd3,  16'hAAAA, 2'd1, 0, 16'h0000, 1, 4'd0,  16'h0020, 16'h1232, 16'h0005, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 0, 4'd15, 16'h0021, 16'h1232, 16'h0080, 4'd0, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0400, 0, 4'd0,  16'h0400, 16'h1232, 16'h0005, 4'd1, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 4'd0,  16'h0007, 2'd0, 0, 16'h0000, 0, 4'd0,  16'h0401, 16'h1232, 16'h0007, 4'd1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0500, 0, 4'd0,  16'h0500, 16'h1232, 16'h0007, 4'd2, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0600, 0, 4'd0,  16'h0501, 16'h1232, 16'h0007, 4'd2, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 1, 4'd0,  16'h0401, 16'h1232, 16'h0007, 4'd1, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 1, 4'd0,  16'h0021, 16'h1232, 16'h0005, 4'd0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 1, 4'd0,  16'h0022, 16'h1232, 16'h0005, 4'd0, 0, 1, 1});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0000, 1, 4'd15, 16'h0000, 16'h1232, 16'h0080, 4'd1, 1, 1, 1});
    vecs.push_back('{1, 0, 0, 4'd0,  16'h0000, 2'd0, 1, 16'h0000, 1, 4'd15, 16'h0000, 16'h1232, 16'h0080, 4'd2, 1, 1, 1});
    vecs.push_back('{1, 1, 0, 4'd0,  16'h0000, 2'd0, 0, 16'h0000, 0, 4'd15, 16'h0000, 16'h1232, 16'h0080, 4'd2, 0, 1, 1});

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, PC_RST);
    chk("rst_sp", sp_out, SP_RST);
    chk("rst_wr", wr_out, 16'h0);
    chk("rst_depth", {12'h0, ctx_depth}, 16'h0);
    rst_n = 1;

    foreach (vecs[k]) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", k), pc_out, vecs[k].e_pc);
      chk($sformatf("v%0d_sp", k), sp_out, vecs[k].e_sp);
      chk($sformatf("v%0d_rd", k), rd_data, vecs[k].e_rd);
      chk($sformatf("v%0d_depth", k), {12'h0, ctx_depth}, {12'h0, vecs[k].e_dep});
      chk($sformatf("v%0d_ack", k), {15'h0, int_ack}, {15'h0, vecs[k].e_ack});
      chk($sformatf("v%0d_ovf", k), {15'h0, ctx_overflow}, {15'h0, vecs[k].e_ovf});
      chk($sformatf("v%0d_unf", k), {15'h0, ctx_underflow}, {15'h0, vecs[k].e_unf});
    end

    // Asynchronous reset in the middle of a cycle while two contexts are stacked.
    idle_inputs();
    rdi = 4'd3;
    #2;
    rst_n = 0;
    #1;
    chk("arst_pc", pc_out, PC_RST);
    chk("arst_sp", sp_out, SP_RST);
    chk("arst_r3", rd_data, 16'h0);
    chk("arst_depth", {12'h0, ctx_depth}, 16'h0);
    chk("arst_ovf", {15'h0, ctx_overflow}, 16'h0);
    chk("arst_unf", {15'h0, ctx_underflow}, 16'h0);
    chk("arst_ack", {15'h0, int_ack}, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();

    for (int n = 0; n < 600; n++) begin
      en   = ($urandom_range(0, 9) != 0);
      st   = ($urandom_range(0, 6) == 0);
      wv   = $urandom_range(0, 1) == 1;
      wi   = 4'($urandom_range(0, 15));
      wd   = 16'($urandom);
      spop = 2'($urandom_range(0, 3));
      ie   = ($urandom_range(0, 7) == 0);
      iv   = 16'($urandom);
      ir   = ($urandom_range(0, 6) == 0);
      rdi  = 4'($urandom_range(0, 15));
      model_step();
      @(posedge clk);
      #1;
      chk("rnd_pc", pc_out, m_reg[PC_IDX]);
      chk("rnd_sp", sp_out, m_reg[SP_IDX]);
      chk("rnd_wr", wr_out, m_reg[WR_IDX]);
      chk("rnd_sr", sr_out, m_reg[SR_IDX]);
      chk("rnd_rd", rd_data, m_reg[rdi]);
      chk("rnd_depth", {12'h0, ctx_depth}, 16'(m_stk.size()));
      chk("rnd_ack", {15'h0, int_ack}, {15'h0, m_ack});
      chk("rnd_ovf", {15'h0, ctx_overflow}, {15'h0, m_ovf});
      chk("rnd_unf", {15'h0, ctx_underflow}, {15'h0, m_unf});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
